if_id_buf: RTL and testbench
============================

Name: if_id_buf

Overview:
- Decoupling stage directly downstream of the IF fetch FSM.
- Accepts each assembled 32-bit instruction with its PC from IF and buffers up to 2 entries. Presents the oldest entry to ID.
- Valid/ready handshake on both sides, synchronous flush for taken branches/jumps, and global `rdy` pause.
- When empty, presents a canonical NOP (ADDI x0,x0,0) so ID always decodes something legal.

Parameters:
- DEPTH, 2, number of buffered entries; only 2 is supported (skid pair).
- NOP_INST, 32'h00000013, instruction word presented to ID when no entry is valid.

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset (sampled on posedge clk only).
- rdy  input  1  global run enable; low freezes all state.
- inst_IF_i  input  32  instruction word from IF.
- pc_IF_i  input  32  address of that instruction.
- valid_IF_i  input  1  IF offers a complete instruction this cycle.
- ready_IF_o  output  1  buffer can accept this cycle.
- flush_i  input  1  discard all buffered and incoming instructions (branch redirect).
- inst_ID_o  output  32  head instruction, or NOP_INST when empty.
- pc_ID_o  output  32  head PC, or 32'h0 when empty.
- valid_ID_o  output  1  head entry is real.
- ready_ID_i  input  1  ID consumes head this cycle.

Behaviour:
- State:
  - two entries {inst, pc}
  - rd_ptr, wr_ptr: 1 bit each, wrap naturally
  - count: 2 bits, range 0..2; the value 3 is illegal.
- Reset: on posedge clk with rst=1, count=0, rd_ptr=wr_ptr=0, entry contents=0. After reset, valid_ID_o=0, inst_ID_o=NOP_INST, pc_ID_o=0, ready_IF_o=1 (if rdy=1).
- ready_IF_o = rdy & (count != 2) & ~flush_i. It is combinational from registered count, so it never depends on ready_ID_i.
- push = valid_IF_i & ready_IF_o.
- pop = valid_ID_o & ready_ID_i & rdy & ~flush_i.
- Outputs are combinational from head registers:
  - valid_ID_o = (count != 0).
  - inst_ID_o = valid_ID_o ? entry[rd_ptr].inst : NOP_INST.
  - pc_ID_o likewise, with 0 when empty.
- Latency: an instruction pushed at edge N is visible to ID after edge N; fall-through within the same cycle is not allowed.
- Count transitions per edge (rdy=1, no flush):
  - push only: +1
  - pop only: -1
  - push & pop: unchanged, write at wr_ptr, advance both pointers.
- Full (count=2) with pop: ready_IF_o is 0 that cycle. Count goes 2 to 1; the next cycle accepts.
- Empty with push: count 0 to 1; no pop is possible that cycle since valid_ID_o=0.
- flush_i=1 (rdy=1): next edge count=0 and rd_ptr=wr_ptr=0. Same-cycle incoming and head are dropped, and ready_IF_o=0 that cycle. Flush has priority over push/pop.
- rst has priority over flush_i and rdy.
- rdy=0: no state change (flush also ignored). ready_IF_o=0. Outputs hold current head, and ID must not treat the held head as consumed.
- Pointer wrap: 1-bit pointers wrap 1 to 0 without special handling.
- Reset mid-operation discards all entries. Any partially assembled IF instruction is IF's concern, not this block's.
- Assertions for the bench:
  - count never exceeds 2.
  - No push while count=2.
  - No pop while count=0.

Decomposition:
- Shared macro.vh constants: `Enable, `Disable, `ZeroWord (existing), plus new `NopInst = 32'h00000013 and `InstBus/`AddrBus width macros (31:0).
- No sub-module is needed; the 2-entry storage is two register pairs in this module.
- The ID decoder instantiates this block directly.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then valid_IF_i=0.
  - Response: valid_ID_o=0, inst_ID_o=32'h00000013, pc_ID_o=0, ready_IF_o=1.
- Single pass-through:
  - Stimulus: push inst 32'h00500093 at pc 0 with ready_ID_i=1.
  - Response: visible the next cycle with pc_ID_o=0, consumed, then count returns to 0 and output reverts to NOP.
- Fill/stall:
  - Stimulus: ready_ID_i=0, push pc 0 and pc 4, offer pc 8.
  - Response: ready_IF_o=0 after the second push, pc 8 not accepted, head stays pc 0.
  - Stimulus: raise ready_ID_i for one cycle.
  - Response: head becomes pc 4 and pc 8 is accepted the following cycle.
- Simultaneous push/pop at count=1:
  - Stimulus: 4 back-to-back instructions pc 0..12 with ready_ID_i=1.
  - Response: ID sees pc 0,4,8,12 in consecutive cycles; count stays 1 throughout; pointers wrap.
- Flush:
  - Stimulus: with count=2 (pc 0,4) and valid_IF_i=1 (pc 8), assert flush_i one cycle.
  - Response: next cycle valid_ID_o=0, pc 8 dropped, ready_IF_o=1.
- rdy pause and mid-op reset:
  - Stimulus: rdy=0 for 3 cycles with count=1 and ready_ID_i=1.
  - Response: head and count unchanged, ready_IF_o=0.
  - Stimulus: rst=1 with count=2.
  - Response: count=0 the next cycle.

Source files
------------

// File: rtl/if_id_buf_pkg.sv
// Shared types and constants for the IF/ID decoupling buffer.
// Widths and the canonical NOP live here so IF, this buffer and ID agree.
package if_id_buf_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [INST_W-1:0] NOP_INST_WORD = 32'h0000_0013;  // ADDI x0,x0,0
  localparam logic [ADDR_W-1:0] ZERO_ADDR     = '0;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } ifid_entry_t;

  // Occupancy update for one accepted edge; callers guarantee push is never
  // set when full and pop is never set when empty.
  function automatic logic [1:0] next_count(input logic [1:0] count,
                                            input logic       push,
                                            input logic       pop);
    return count + {1'b0, push} - {1'b0, pop};
  endfunction

endpackage

// File: rtl/if_id_buf.sv
// Two-entry skid buffer between the IF fetch FSM and the ID decoder.
// Presents the oldest entry to ID, or a NOP when nothing is buffered.
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [INST_W-1:0] inst_IF_i,
  input  logic [ADDR_W-1:0] pc_IF_i,
  input  logic              valid_IF_i,
  output logic              ready_IF_o,
  input  logic              flush_i,
  output logic [INST_W-1:0] inst_ID_o,
  output logic [ADDR_W-1:0] pc_ID_o,
  output logic              valid_ID_o,
  input  logic              ready_ID_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  ifid_entry_t      entry_q [DEPTH];
  ifid_entry_t      entry_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push;
  logic pop;

  // Handshake is derived only from registered occupancy, so ready_IF_o
  // never combinationally depends on ready_ID_i.
  always_comb begin
    ready_IF_o = rdy & (count_q != FULL_CNT) & ~flush_i;
    valid_ID_o = (count_q != '0);
    push       = valid_IF_i & ready_IF_o;
    pop        = valid_ID_o & ready_ID_i & rdy & ~flush_i;
    inst_ID_o  = valid_ID_o ? entry_q[rd_ptr_q].inst : NOP_INST;
    pc_ID_o    = valid_ID_o ? entry_q[rd_ptr_q].pc   : ZERO_ADDR;
  end

  always_comb begin
    entry_d  = entry_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (rdy) begin
      if (flush_i) begin
        // Stale entries stay in storage; count=0 hides them from ID.
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (push) begin
          entry_d[wr_ptr_q].inst = inst_IF_i;
          entry_d[wr_ptr_q].pc   = pc_IF_i;
          wr_ptr_d               = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = next_count(count_q, push, pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      entry_q  <= entry_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_if_id_buf.sv
// Self-checking bench for if_id_buf: directed scenarios followed by random
// traffic, all compared against a queue-based FIFO reference model.
module tb_if_id_buf;

  logic        clk = 1'b0;
  logic        rst, rdy, valid_IF_i, flush_i, ready_ID_i;
  logic [31:0] inst_IF_i, pc_IF_i;
  logic        ready_IF_o, valid_ID_o;
  logic [31:0] inst_ID_o, pc_ID_o;

  int n_checks = 0;
  int n_errors = 0;
  bit model_known = 1'b0;

  logic [63:0] q[$];  // {inst, pc}, oldest first

  always #5 clk = ~clk;

  if_id_buf dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .inst_IF_i  (inst_IF_i),
    .pc_IF_i    (pc_IF_i),
    .valid_IF_i (valid_IF_i),
    .ready_IF_o (ready_IF_o),
    .flush_i    (flush_i),
    .inst_ID_o  (inst_ID_o),
    .pc_ID_o    (pc_ID_o),
    .valid_ID_o (valid_ID_o),
    .ready_ID_i (ready_ID_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input logic r, input logic rd, input logic vif,
                      input logic [31:0] inst, input logic [31:0] pc,
                      input logic fl, input logic rid);
    logic        exp_ready, exp_valid, do_push, do_pop;
    logic [31:0] exp_inst, exp_pc;
    rst = r; rdy = rd; valid_IF_i = vif; inst_IF_i = inst; pc_IF_i = pc;
    flush_i = fl; ready_ID_i = rid;
    @(negedge clk);
    exp_ready = rd && (q.size() < 2) && !fl;
    exp_valid = (q.size() > 0);
    exp_inst  = exp_valid ? q[0][63:32] : 32'h0000_0013;
    exp_pc    = exp_valid ? q[0][31:0]  : 32'h0;
    if (model_known) begin
      chk("ready_IF", {31'b0, ready_IF_o}, {31'b0, exp_ready});
      chk("valid_ID", {31'b0, valid_ID_o}, {31'b0, exp_valid});
      chk("inst_ID", inst_ID_o, exp_inst);
      chk("pc_ID", pc_ID_o, exp_pc);
      chk("count", {30'b0, dut.count_q}, q.size());
    end
    do_push = vif && exp_ready;
    do_pop  = exp_valid && rid && rd && !fl;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      model_known = 1'b1;
    end else if (rd) begin
      if (fl) q.delete();
      else begin
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back({inst, pc});
      end
    end
  endtask

  task automatic idle(input logic rid);
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, rid);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; valid_IF_i = 1'b0; inst_IF_i = '0; pc_IF_i = '0;
    flush_i = 1'b0; ready_ID_i = 1'b0;

    // Reset then idle
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Single pass-through
    step(1'b0, 1'b1, 1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Fill and stall, then one pop frees a slot for pc 8
    step(1'b0, 1'b1, 1'b1, 32'h1000_0000, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h1000_0004, 32'h4, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h1000_0008, 32'h8, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h1000_0008, 32'h8, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h1000_0008, 32'h8, 1'b0, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Back-to-back with simultaneous push/pop, pointers wrap
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 1'b1, 32'h2000_0000 + 32'(i), 32'(4 * i), 1'b0, 1'b1);
    idle(1'b1); idle(1'b1);

    // Flush while full with an instruction offered
    step(1'b0, 1'b1, 1'b1, 32'h3000_0000, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h3000_0004, 32'h4, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h3000_0008, 32'h8, 1'b1, 1'b1);
    idle(1'b0);

    // rdy pause with count=1, then mid-operation reset with count=2
    step(1'b0, 1'b1, 1'b1, 32'h4000_0000, 32'h40, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b1, 32'h4000_0004, 32'h44, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h4000_0004, 32'h44, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h4000_0008, 32'h48, 1'b0, 1'b1);
    idle(1'b0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(7) != 0), 1'($urandom),
           $urandom, $urandom, ($urandom_range(15) == 0), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
